// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and pointer sizing.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 8;

    // Keeps a one-bit pointer legal for the smallest depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned FIFO_PTR_W = ptr_width(FIFO_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read at the read pointer.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // No reset: stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO control: pointers, occupancy count and the registered read port.
module fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [WIDTH-1:0] fifo_out
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Flags follow the registered count; reset forces the empty view immediately.
    always_comb begin
        w_empty   = reset || (r_count == '0);
        w_full    = !reset && (r_count == FULL_CNT);
        w_pop_ok  = pop && !w_empty;
        w_push_ok = push && (!w_full || w_pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_out    <= w_rdata;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push_ok && !reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (dataIn),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign fifo_out   = r_out;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: vector table, directed corner sequences and a random run
// checked against a queue-based reference model.
module tb_fifo;

    localparam int unsigned W = 32;
    localparam int unsigned D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic [W-1:0] dataIn = '0;
    logic         fifo_full;
    logic         fifo_empty;
    logic [W-1:0] fifo_out;

    always #5 clk = ~clk;

    fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .dataIn     (dataIn),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out)
    );

    int total = 0;
    int bad = 0;

    // Reference model: contents as a queue, plus the last popped word.
    logic [W-1:0] q[$];
    logic [W-1:0] m_out = '0;

    typedef struct {
        logic         rst;
        logic         psh;
        logic         pp;
        logic [W-1:0] din;
        logic [W-1:0] eout;
        logic         eempty;
        logic         efull;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, update model at the edge, compare #1 later.
    task automatic step(input string tag, input logic r, input logic p, input logic o,
                        input logic [W-1:0] d);
        bit pop_ok;
        bit push_ok;
        reset = r;
        push = p;
        pop = o;
        dataIn = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_out = '0;
        end else begin
            pop_ok = o && (q.size() > 0);
            push_ok = p && ((q.size() < D) || pop_ok);
            if (pop_ok) m_out = q.pop_front();
            if (push_ok) q.push_back(d);
        end
        #1;
        chk({tag, "_out"}, fifo_out, m_out);
        chk({tag, "_empty"}, W'(fifo_empty), W'(q.size() == 0));
        chk({tag, "_full"}, W'(fifo_full), W'(q.size() == D));
        reset = 1'b0;
        push = 1'b0;
        pop = 1'b0;
    endtask

    initial begin
        // Hand-derived vectors: reset, push 1..3, idle, pop x3, empty pop, push+pop on empty.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'd7, 32'd3, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd7, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd9, 32'd0, 1'b1, 1'b0};

        for (int k = 0; k < 12; k++) begin
            step("tbl", tbl[k].rst, tbl[k].psh, tbl[k].pp, tbl[k].din);
            chk($sformatf("vec%0d_out", k), fifo_out, tbl[k].eout);
            chk($sformatf("vec%0d_empty", k), W'(fifo_empty), W'(tbl[k].eempty));
            chk($sformatf("vec%0d_full", k), W'(fifo_full), W'(tbl[k].efull));
        end

        // Overfill: 10..18, the ninth push is dropped.
        for (int i = 0; i < 9; i++) begin
            step("ovf", 1'b0, 1'b1, 1'b0, W'(10 + i));
            if (i >= 7) chk("ovf_full", W'(fifo_full), W'(1));
        end
        for (int i = 0; i < 8; i++) begin
            step("ovf_pop", 1'b0, 1'b0, 1'b1, '0);
            chk("ovf_order", fifo_out, W'(10 + i));
        end
        chk("ovf_drained", W'(fifo_empty), W'(1));

        // Pop while empty holds the last word.
        step("e", 1'b0, 1'b1, 1'b0, W'(5));
        step("e", 1'b0, 1'b0, 1'b1, '0);
        step("e", 1'b0, 1'b0, 1'b1, '0);
        chk("empty_pop_hold", fifo_out, W'(5));
        chk("empty_pop_flag", W'(fifo_empty), W'(1));

        // Push+pop while full, running the pointers past the wrap point.
        for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 1'b0, W'(100 + i));
        for (int i = 0; i < 12; i++) begin
            step("pp", 1'b0, 1'b1, 1'b1, W'(200 + i));
            chk("pp_order", fifo_out, (i < 8) ? W'(100 + i) : W'(200 + i - 8));
            chk("pp_full", W'(fifo_full), W'(1));
        end
        for (int i = 0; i < 8; i++) begin
            step("wrap_pop", 1'b0, 1'b0, 1'b1, '0);
            chk("wrap_order", fifo_out, W'(204 + i));
        end
        step("pp_empty", 1'b0, 1'b1, 1'b1, W'(300));
        chk("pp_empty_hold", fifo_out, W'(211));
        chk("pp_empty_stored", W'(fifo_empty), W'(0));
        step("pp_empty", 1'b0, 1'b0, 1'b1, '0);
        chk("pp_empty_word", fifo_out, W'(300));

        // Flags while reset is held on a full FIFO, before the edge.
        for (int i = 0; i < 8; i++) step("fill2", 1'b0, 1'b1, 1'b0, W'(400 + i));
        reset = 1'b1;
        #1;
        chk("rst_comb_empty", W'(fifo_empty), W'(1));
        chk("rst_comb_full", W'(fifo_full), W'(0));
        step("rst_prio", 1'b1, 1'b1, 1'b1, W'(55));
        chk("rst_prio_out", fifo_out, W'(0));

        // Reset one cycle after a pop, then idle.
        for (int i = 0; i < 3; i++) step("r", 1'b0, 1'b1, 1'b0, W'(60 + i));
        step("r", 1'b0, 1'b0, 1'b1, '0);
        chk("r_popped", fifo_out, W'(60));
        step("r", 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step("r_idle", 1'b0, 1'b0, 1'b0, '0);
        chk("r_idle_out", fifo_out, W'(0));
        chk("r_idle_empty", W'(fifo_empty), W'(1));

        // Random traffic with phase-dependent push/pop bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned pp_bias;
            int unsigned po_bias;
            pp_bias = (i / 500) % 3 == 0 ? 75 : ((i / 500) % 3 == 1 ? 30 : 50);
            po_bias = 100 - pp_bias;
            step("rnd", ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < pp_bias), ($urandom_range(0, 99) < po_bias),
                 W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter: WIDTH, 32, data word width in bits.
REQ-002 Parameter: DEPTH, 8, number of storage entries; SHALL be a power of two, 2 or greater.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: push  input  1  write request; dataIn written at rising edge when accepted.
REQ-006 Port: pop  input  1  read request; head entry read at rising edge when accepted.
REQ-007 Port: dataIn  input  WIDTH  write data.
REQ-008 Port: fifo_full  output  1  high when occupancy equals DEPTH.
REQ-009 Port: fifo_empty  output  1  high when occupancy equals 0.
REQ-010 Port: fifo_out  output  WIDTH  registered read data.

Function
REQ-011 Storage SHALL be a DEPTH x WIDTH array with a write pointer, a read pointer and an occupancy count of width clog2(DEPTH)+1.
REQ-012 A push SHALL be accepted when push=1 and (fifo_full=0 or an accepted pop occurs in the same cycle).
- On acceptance, dataIn is stored at the write pointer.
- The write pointer increments modulo DEPTH.
REQ-013 A pop SHALL be accepted when pop=1 and fifo_empty=0.
- On acceptance, fifo_out loads the entry at the read pointer on that edge (1-cycle latency).
- The read pointer increments modulo DEPTH.
REQ-014 fifo_out SHALL hold its value in every cycle without an accepted pop.
REQ-015 A push while full with no pop SHALL be dropped: no pointer, count or data change.
REQ-016 A pop while empty SHALL be ignored: fifo_out holds and pointers are unchanged.
REQ-017 Simultaneous push and pop SHALL behave as follows:
- Non-empty: both are accepted and count is unchanged.
- Empty: only the push is accepted.
REQ-018 Count SHALL change by +1 on an accepted push alone, -1 on an accepted pop alone, and 0 otherwise.
REQ-019 fifo_full and fifo_empty SHALL be decoded combinationally from the registered count, reflecting the state after the most recent edge.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering (strict first-in first-out).

Reset
REQ-021 While reset=1 at a rising edge, the following SHALL clear to 0: pointers, count and fifo_out.
REQ-022 During reset, fifo_empty=1 and fifo_full=0.
REQ-023 Reset SHALL take priority over push and pop in the same cycle; a reset mid-operation discards all contents.
REQ-024 Storage array contents need not be cleared by reset.

Structure
REQ-025 A shared package fifo_pkg SHALL hold the default WIDTH and DEPTH constants and a pointer-width constant derived from clog2(DEPTH).
REQ-026 Storage SHALL be one sub-module, fifo_mem (synchronous write, read port addressed by the read pointer); all control logic stays in fifo.

Verification
REQ-027 Scenario: reset, then push 1,2,3 on three consecutive edges -> fifo_empty=0, fifo_full=0, fifo_out=0.
REQ-028 Scenario: one idle cycle, then pop on three consecutive edges -> fifo_out=1, 2, 3 after each edge, then fifo_empty=1.
REQ-029 Scenario: reset one cycle after data pops, then 10 idle cycles -> fifo_out=0, fifo_empty=1.
REQ-030 Scenario: push DEPTH+1 values 10..18 -> fifo_full=1 after the 8th push, 18 dropped; popping all returns 10..17 in order.
REQ-031 Scenario: pop while empty after fifo_out=5 -> fifo_out stays 5, fifo_empty stays 1.
REQ-032 Scenario: simultaneous push and pop while full, and across pointer wrap -> count stays 8, order is preserved; push+pop when empty stores the word and leaves fifo_out unchanged.
